// File: rtl/mem_access_stage_pkg.sv
// rtl/mem_access_stage_pkg.sv - pipe_pkg: shared widths, funct3 encodings, FSM states and store helpers.
package pipe_pkg;

  localparam int XLEN = 32;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2
  } mem_state_t;

  function automatic logic [3:0] store_be(input logic [2:0] funct3, input logic [1:0] addr_lo);
    case (funct3)
      F3_SB:   store_be = 4'b0001 << addr_lo;
      F3_SH:   store_be = 4'b0011 << {addr_lo[1], 1'b0};
      default: store_be = 4'b1111;
    endcase
  endfunction

  function automatic logic [XLEN-1:0] store_wdata(input logic [2:0] funct3, input logic [XLEN-1:0] data);
    case (funct3)
      F3_SB:   store_wdata = {4{data[7:0]}};
      F3_SH:   store_wdata = {2{data[15:0]}};
      default: store_wdata = data;
    endcase
  endfunction

  // Halfword needs addr[0]==0, word needs addr[1:0]==0; loads 010/011/110/111 and stores other than SB/SH are words.
  function automatic logic access_misaligned(input logic is_store, input logic [2:0] funct3,
                                             input logic [1:0] addr_lo);
    logic is_half;
    logic is_word;
    if (is_store) begin
      is_half = (funct3 == F3_SH);
      is_word = (funct3 != F3_SB) && (funct3 != F3_SH);
    end else begin
      is_half = (funct3 == F3_LH) || (funct3 == F3_LHU);
      is_word = funct3[1] || (funct3 == F3_LW) || (funct3 == F3_SW);
    end
    access_misaligned = (is_half && addr_lo[0]) || (is_word && (addr_lo != 2'b00));
  endfunction

endpackage

// File: rtl/mem_access_stage_if.sv
// rtl/mem_access_stage_if.sv - request/grant/response data-memory port with master (stage) and slave (memory) views.
interface mem_access_stage_if;
  import pipe_pkg::*;

  logic            dmem_req;
  logic            dmem_we;
  logic [XLEN-1:0] dmem_addr;
  logic [XLEN-1:0] dmem_wdata;
  logic [3:0]      dmem_be;
  logic            dmem_gnt;
  logic            dmem_rvalid;
  logic [XLEN-1:0] dmem_rdata;

  modport master (
    output dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
    input  dmem_gnt, dmem_rvalid, dmem_rdata
  );

  modport slave (
    input  dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
    output dmem_gnt, dmem_rvalid, dmem_rdata
  );

endinterface

// File: rtl/mem_access_stage_load_align.sv
// rtl/mem_access_stage_load_align.sv - load_align: lane select and sign/zero extension of load data.
module load_align
  import pipe_pkg::*;
(
  input  logic [XLEN-1:0] rdata,
  input  logic [1:0]      addr_lo,
  input  logic [2:0]      funct3,
  output logic [XLEN-1:0] data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = rdata[{addr_lo, 3'b000} +: 8];
    half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];
    case (funct3)
      F3_LB:   data = {{24{byte_sel[7]}}, byte_sel};
      F3_LBU:  data = {24'b0, byte_sel};
      F3_LH:   data = {{16{half_sel[15]}}, half_sel};
      F3_LHU:  data = {16'b0, half_sel};
      default: data = rdata;
    endcase
  end

endmodule

// File: rtl/mem_access_stage.sv
// rtl/mem_access_stage.sv - memory-access pipeline stage; optional MISALIGN_TRAP_EN traps misaligned accesses.
module mem_access_stage
  import pipe_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [XLEN-1:0]     alu_result,
  input  logic [XLEN-1:0]     store_data,
  input  logic                mem_read,
  input  logic                mem_write,
  input  logic [2:0]          funct3,
  input  logic [4:0]          rd,
  input  logic                reg_write,
  mem_access_stage_if.master  dmem,
  output logic                wb_valid,
  output logic                wb_reg_write,
  output logic [4:0]          wb_rd,
  output logic [XLEN-1:0]     wb_data,
  output logic                misalign_err
);

  mem_state_t      state_q, state_d;
  logic            req_q, req_d;
  logic            we_q, we_d;
  logic [XLEN-1:0] addr_q, addr_d;
  logic [XLEN-1:0] wdata_q, wdata_d;
  logic [3:0]      be_q, be_d;
  logic [1:0]      addr_lo_q, addr_lo_d;
  logic [2:0]      f3_q, f3_d;
  logic [4:0]      rd_q, rd_d;
  logic            wreg_q, wreg_d;
  logic            wb_valid_q, wb_valid_d;
  logic            wb_wreg_q, wb_wreg_d;
  logic [4:0]      wb_rd_q, wb_rd_d;
  logic [XLEN-1:0] wb_data_q, wb_data_d;
  logic [XLEN-1:0] load_data;
  logic            accept;
  logic            is_mem;

`ifdef MISALIGN_TRAP_EN
  logic mis_q, mis_d;
`endif

  // Gated by rst so the handshake reads 0 while reset is held.
  assign in_ready = (state_q == IDLE) && !rst;
  assign accept   = in_valid && in_ready;
  assign is_mem   = mem_read || mem_write;

  load_align u_load_align (
    .rdata   (dmem.dmem_rdata),
    .addr_lo (addr_lo_q),
    .funct3  (f3_q),
    .data    (load_data)
  );

  always_comb begin
    state_d    = state_q;
    req_d      = req_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    be_d       = be_q;
    addr_lo_d  = addr_lo_q;
    f3_d       = f3_q;
    rd_d       = rd_q;
    wreg_d     = wreg_q;
    wb_valid_d = 1'b0;
    wb_wreg_d  = wb_wreg_q;
    wb_rd_d    = wb_rd_q;
    wb_data_d  = wb_data_q;
`ifdef MISALIGN_TRAP_EN
    mis_d      = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (accept) begin
          rd_d      = rd;
          wreg_d    = reg_write && (rd != 5'd0);
          f3_d      = funct3;
          addr_lo_d = alu_result[1:0];
          if (!is_mem) begin
            wb_valid_d = 1'b1;
            wb_wreg_d  = reg_write && (rd != 5'd0);
            wb_rd_d    = rd;
            wb_data_d  = alu_result;
          end
`ifdef MISALIGN_TRAP_EN
          else if (access_misaligned(mem_write, funct3, alu_result[1:0])) begin
            wb_valid_d = 1'b1;
            wb_wreg_d  = 1'b0;
            wb_rd_d    = rd;
            mis_d      = 1'b1;
          end
`endif
          else begin
            state_d = REQ;
            req_d   = 1'b1;
            we_d    = mem_write;
            addr_d  = {alu_result[31:2], 2'b00};
            be_d    = mem_write ? store_be(funct3, alu_result[1:0]) : 4'b1111;
            wdata_d = mem_write ? store_wdata(funct3, store_data) : '0;
          end
        end
      end
      REQ: begin
        if (dmem.dmem_gnt) begin
          req_d = 1'b0;
          if (we_q) begin
            state_d    = IDLE;
            wb_valid_d = 1'b1;
            wb_wreg_d  = 1'b0;
            wb_rd_d    = rd_q;
            wb_data_d  = '0;
          end else begin
            state_d = RESP;
          end
        end
      end
      RESP: begin
        if (dmem.dmem_rvalid) begin
          state_d    = IDLE;
          wb_valid_d = 1'b1;
          wb_wreg_d  = wreg_q;
          wb_rd_d    = rd_q;
          wb_data_d  = load_data;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      req_q      <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      be_q       <= '0;
      addr_lo_q  <= '0;
      f3_q       <= '0;
      rd_q       <= '0;
      wreg_q     <= 1'b0;
      wb_valid_q <= 1'b0;
      wb_wreg_q  <= 1'b0;
      wb_rd_q    <= '0;
      wb_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      req_q      <= req_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      be_q       <= be_d;
      addr_lo_q  <= addr_lo_d;
      f3_q       <= f3_d;
      rd_q       <= rd_d;
      wreg_q     <= wreg_d;
      wb_valid_q <= wb_valid_d;
      wb_wreg_q  <= wb_wreg_d;
      wb_rd_q    <= wb_rd_d;
      wb_data_q  <= wb_data_d;
    end
  end

`ifdef MISALIGN_TRAP_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) mis_q <= 1'b0;
    else     mis_q <= mis_d;
  end
  assign misalign_err = mis_q;
`else
  assign misalign_err = 1'b0;
`endif

  assign dmem.dmem_req   = req_q;
  assign dmem.dmem_we    = we_q;
  assign dmem.dmem_addr  = addr_q;
  assign dmem.dmem_wdata = wdata_q;
  assign dmem.dmem_be    = be_q;

  assign wb_valid     = wb_valid_q;
  assign wb_reg_write = wb_wreg_q;
  assign wb_rd        = wb_rd_q;
  assign wb_data      = wb_data_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// tb/tb_mem_access_stage.sv - directed and random checks of mem_access_stage against a behavioural model.
module tb_mem_access_stage;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] alu_result;
  logic [31:0] store_data;
  logic        mem_read;
  logic        mem_write;
  logic [2:0]  funct3;
  logic [4:0]  rd;
  logic        reg_write;
  logic        wb_valid;
  logic        wb_reg_write;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        misalign_err;

  int n_tests = 0;
  int n_fail  = 0;

  mem_access_stage_if bus ();

  mem_access_stage dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .alu_result   (alu_result),
    .store_data   (store_data),
    .mem_read     (mem_read),
    .mem_write    (mem_write),
    .funct3       (funct3),
    .rd           (rd),
    .reg_write    (reg_write),
    .dmem         (bus),
    .wb_valid     (wb_valid),
    .wb_reg_write (wb_reg_write),
    .wb_rd        (wb_rd),
    .wb_data      (wb_data),
    .misalign_err (misalign_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] m_load(input logic [31:0] rdata, input logic [1:0] a, input logic [2:0] f3);
    logic [31:0] v;
    if (f3 == 3'd0 || f3 == 3'd4) begin
      v = (rdata >> (8 * int'(a))) & 32'hFF;
      if (f3 == 3'd0 && v >= 32'd128) v = v - 32'd256;
    end else if (f3 == 3'd1 || f3 == 3'd5) begin
      v = (rdata >> (16 * int'(a[1]))) & 32'hFFFF;
      if (f3 == 3'd1 && v >= 32'd32768) v = v - 32'd65536;
    end else begin
      v = rdata;
    end
    return v;
  endfunction

  function automatic logic [3:0] m_be(input logic [2:0] f3, input logic [1:0] a);
    if (f3 == 3'd0) return 4'(1 << int'(a));
    if (f3 == 3'd1) return 4'(3 << (2 * int'(a[1])));
    return 4'hF;
  endfunction

  function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] sd);
    if (f3 == 3'd0) return (sd & 32'hFF) * 32'h0101_0101;
    if (f3 == 3'd1) return (sd & 32'hFFFF) * 32'h0001_0001;
    return sd;
  endfunction

  function automatic logic m_mis(input logic st, input logic [2:0] f3, input logic [1:0] a);
`ifdef MISALIGN_TRAP_EN
    int size;
    if (st) size = (f3 == 3'd0) ? 1 : (f3 == 3'd1) ? 2 : 4;
    else    size = (f3 == 3'd0 || f3 == 3'd4) ? 1 : (f3 == 3'd1 || f3 == 3'd5) ? 2 : 4;
    return (int'(a) % size) != 0;
`else
    return 1'b0;
`endif
  endfunction

  // Issue one instruction and follow it to its writeback, checking every cycle on the way.
  task automatic run_op(input logic mr, input logic mw, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] sd, input logic [31:0] rdat, input logic [4:0] rdi,
                        input logic rw, input int gd, input int rspd, input logic junk);
    logic st, mem, mis, exp_wr;
    st     = mw;
    mem    = mr | mw;
    mis    = mem && m_mis(st, f3, addr[1:0]);
    exp_wr = rw && (rdi != 5'd0);
    chk1("rdy_pre", in_ready, 1'b1);
    in_valid = 1'b1; mem_read = mr; mem_write = mw; funct3 = f3;
    alu_result = addr; store_data = sd; rd = rdi; reg_write = rw;
    @(posedge clk); #1;
    in_valid = 1'b0; alu_result = $urandom; store_data = $urandom;
    funct3 = 3'($urandom); rd = 5'($urandom); reg_write = 1'($urandom);
    if (!mem || mis) begin
      chk1("wb_valid_direct", wb_valid, 1'b1);
      chk1("wb_wr_direct", wb_reg_write, mis ? 1'b0 : exp_wr);
      if (!mis) chk("wb_rd_direct", 32'(wb_rd), 32'(rdi));
      if (!mis) chk("wb_data_alu", wb_data, addr);
      chk1("misalign_err", misalign_err, mis);
      chk1("no_req_direct", bus.dmem_req, 1'b0);
      chk1("rdy_direct", in_ready, 1'b1);
      return;
    end
    for (int k = 0; k <= gd; k++) begin
      chk1("req_hold", bus.dmem_req, 1'b1);
      chk1("we", bus.dmem_we, st);
      chk("addr", bus.dmem_addr, addr & 32'hFFFF_FFFC);
      if (st) chk("be", 32'(bus.dmem_be), 32'(m_be(f3, addr[1:0])));
      if (st) chk("wdata", bus.dmem_wdata, m_wdata(f3, sd));
      chk1("rdy_req", in_ready, 1'b0);
      chk1("wb_idle_req", wb_valid, 1'b0);
      if (junk) begin bus.dmem_rvalid = 1'b1; bus.dmem_rdata = $urandom; end
      bus.dmem_gnt = (k == gd);
      @(posedge clk); #1;
      bus.dmem_gnt = 1'b0; bus.dmem_rvalid = 1'b0;
    end
    if (st) begin
      chk1("wb_valid_st", wb_valid, 1'b1);
      chk1("wb_wr_st", wb_reg_write, 1'b0);
      chk1("req_drop_st", bus.dmem_req, 1'b0);
      chk1("rdy_st", in_ready, 1'b1);
      chk1("misalign_st", misalign_err, 1'b0);
      return;
    end
    for (int k = 0; k <= rspd; k++) begin
      chk1("req_drop_ld", bus.dmem_req, 1'b0);
      chk1("rdy_resp", in_ready, 1'b0);
      chk1("wb_idle_resp", wb_valid, 1'b0);
      if (k == rspd) begin bus.dmem_rvalid = 1'b1; bus.dmem_rdata = rdat; end
      @(posedge clk); #1;
      bus.dmem_rvalid = 1'b0; bus.dmem_rdata = $urandom;
    end
    chk1("wb_valid_ld", wb_valid, 1'b1);
    chk("wb_data_ld", wb_data, m_load(rdat, addr[1:0], f3));
    chk("wb_rd_ld", 32'(wb_rd), 32'(rdi));
    chk1("wb_wr_ld", wb_reg_write, exp_wr);
    chk1("rdy_ld", in_ready, 1'b1);
    chk1("misalign_ld", misalign_err, 1'b0);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; mem_read = 1'b0; mem_write = 1'b0; funct3 = 3'd0;
    alu_result = '0; store_data = '0; rd = '0; reg_write = 1'b0;
    bus.dmem_gnt = 1'b0; bus.dmem_rvalid = 1'b0; bus.dmem_rdata = '0;

    repeat (2) @(posedge clk); #1;
    chk1("rst_in_ready", in_ready, 1'b0);
    chk1("rst_wb_valid", wb_valid, 1'b0);
    chk1("rst_req", bus.dmem_req, 1'b0);
    chk("rst_addr", bus.dmem_addr, 32'h0);
    chk("rst_wb_data", wb_data, 32'h0);
    chk1("rst_misalign", misalign_err, 1'b0);
    rst = 1'b0; #1;
    chk1("post_rst_ready", in_ready, 1'b1);
    @(posedge clk); #1;

    // Four back-to-back ALU results, one writeback pulse each cycle.
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; mem_read = 1'b0; mem_write = 1'b0;
      alu_result = 32'h0000_1234 + 32'(i); rd = 5'd5; reg_write = 1'b1;
      @(posedge clk); #1;
      chk1("b2b_wb_valid", wb_valid, 1'b1);
      chk("b2b_wb_data", wb_data, 32'h0000_1234 + 32'(i));
      chk("b2b_wb_rd", 32'(wb_rd), 32'd5);
      chk1("b2b_wb_wr", wb_reg_write, 1'b1);
      chk1("b2b_ready", in_ready, 1'b1);
    end
    in_valid = 1'b0;
    @(posedge clk); #1;
    chk1("b2b_end", wb_valid, 1'b0);

    run_op(1'b0, 1'b1, 3'b000, 32'h0000_0103, 32'h0000_00A5, 32'h0, 5'd1, 1'b1, 2, 0, 1'b0);
    run_op(1'b1, 1'b0, 3'b000, 32'h0000_0102, 32'h0, 32'h0080_0000, 5'd6, 1'b1, 0, 0, 1'b0);
    chk("lb_const", wb_data, 32'hFFFF_FF80);
    run_op(1'b1, 1'b0, 3'b100, 32'h0000_0102, 32'h0, 32'h0080_0000, 5'd6, 1'b1, 1, 2, 1'b1);
    chk("lbu_const", wb_data, 32'h0000_0080);
    run_op(1'b1, 1'b0, 3'b001, 32'h0000_0102, 32'h0, 32'h8001_0000, 5'd9, 1'b1, 0, 1, 1'b1);
    chk("lh_const", wb_data, 32'hFFFF_8001);
    run_op(1'b1, 1'b0, 3'b010, 32'h0000_0200, 32'h0, 32'hDEAD_BEEF, 5'd0, 1'b1, 1, 1, 1'b1);
    chk1("lw_rd0_wr", wb_reg_write, 1'b0);
    run_op(1'b1, 1'b1, 3'b001, 32'h0000_0302, 32'h0000_BEEF, 32'h0, 5'd4, 1'b1, 0, 0, 1'b0);

    bus.dmem_rvalid = 1'b1; bus.dmem_rdata = $urandom;
    @(posedge clk); #1;
    bus.dmem_rvalid = 1'b0;
    chk1("rvalid_idle_wb", wb_valid, 1'b0);
    chk1("rvalid_idle_rdy", in_ready, 1'b1);

    // Reset asserted mid-request drops the strobe at once.
    in_valid = 1'b1; mem_read = 1'b1; mem_write = 1'b0; funct3 = 3'b010;
    alu_result = 32'h0000_0400; rd = 5'd3; reg_write = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk1("pre_rst_req", bus.dmem_req, 1'b1);
    rst = 1'b1; #1;
    chk1("rst_req_drop", bus.dmem_req, 1'b0);
    chk1("rst_req_rdy", in_ready, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    bus.dmem_gnt = 1'b1;
    @(posedge clk); #1;
    bus.dmem_gnt = 1'b0;
    chk1("resp_rdy_low", in_ready, 1'b0);
    rst = 1'b1; #1;
    chk1("rst_resp_req", bus.dmem_req, 1'b0);
    chk1("rst_resp_wb", wb_valid, 1'b0);
    chk1("rst_resp_rdy", in_ready, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0; #1;
    chk1("rst_resp_rdy_rel", in_ready, 1'b1);
    bus.dmem_rvalid = 1'b1; bus.dmem_rdata = 32'h1234_5678;
    @(posedge clk); #1;
    bus.dmem_rvalid = 1'b0;
    chk1("late_rvalid_wb", wb_valid, 1'b0);
    chk1("late_rvalid_rdy", in_ready, 1'b1);

    run_op(1'b1, 1'b0, 3'b010, 32'h0000_0102, 32'h0, 32'h1234_5678, 5'd7, 1'b1, 0, 0, 1'b0);
`ifdef MISALIGN_TRAP_EN
    chk1("mis_lw_err", misalign_err, 1'b1);
    chk1("mis_lw_wr", wb_reg_write, 1'b0);
`else
    chk("nomis_lw_data", wb_data, 32'h1234_5678);
`endif

    for (int i = 0; i < 60; i++) begin
      int kind;
      kind = int'($urandom_range(0, 3));
      run_op(kind == 1 || kind == 3, kind >= 2, 3'($urandom), $urandom, $urandom, $urandom,
             5'($urandom), 1'($urandom), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
             1'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_access_stage.md
# mem_access_stage

Pipeline stage that consumes the execute stage's ALU result and register operand, and performs the data-memory access for loads and stores. It drives a request/grant/response data-memory port, aligns and extends load data, and produces a single-cycle writeback record. Non-memory instructions pass through with one-cycle latency. `in_ready` stalls the upstream stages while an access is outstanding.

## Interface
- No parameters. Widths are fixed: XLEN=32 and a 5-bit register index.
- `clk` in 1: the single clock.
- `rst` in 1: asynchronous, active-high reset.
- `in_valid` in 1: upstream instruction valid.
- `in_ready` out 1: stage can accept. High only in IDLE.
- `alu_result` in 32: ALU output, used as the address for memory ops and the writeback value otherwise.
- `store_data` in 32: rs2 value for stores.
- `mem_read`, `mem_write` in 1 each: access type. If both are set, `mem_write` wins.
- `funct3` in 3: access width and signedness.
- `rd` in 5: destination register.
- `reg_write` in 1: writeback enable.
- `dmem_req` out 1, `dmem_we` out 1: request strobe and write enable.
- `dmem_addr` out 32: word-aligned address, `{addr[31:2],2'b00}`.
- `dmem_wdata` out 32, `dmem_be` out 4: lane-replicated store data and byte enables.
- `dmem_gnt` in 1: request accepted.
- `dmem_rvalid` in 1, `dmem_rdata` in 32: load response.
- `wb_valid` out 1: single-cycle writeback pulse.
- `wb_reg_write` out 1, `wb_rd` out 5, `wb_data` out 32: writeback record.
- `misalign_err` out 1: misaligned-access pulse. Tied to 0 unless the macro is defined.

## Operation
- An instruction is accepted when `in_valid & in_ready`. All inputs are latched on acceptance.
- States:
  - IDLE: `in_ready`=1.
    - Accepting a non-memory op: stay in IDLE, load the writeback registers with `wb_data=alu_result`.
    - Accepting a memory op: go to REQ.
  - REQ: `dmem_req`=1, other `dmem_*` outputs driven from latched values.
    - `dmem_gnt` with a store: go to IDLE and emit writeback with `wb_reg_write`=0.
    - `dmem_gnt` with a load: go to RESP.
  - RESP: wait for `dmem_rvalid`, then go to IDLE and emit writeback with extended data.
- `dmem_rvalid` is ignored outside RESP.
- Loads: lane selected by `addr[1:0]`.
  - funct3 000 LB: sign-extend.
  - funct3 100 LBU: zero-extend.
  - funct3 001 LH: sign-extend. Lane from `addr[1]`.
  - funct3 101 LHU: zero-extend. Lane from `addr[1]`.
  - funct3 010, 011, 110, 111: treated as LW.
- Stores:
  - SB: `dmem_be=4'b0001<<addr[1:0]`, `wdata={4{byte}}`.
  - SH: `dmem_be=4'b0011<<{addr[1],1'b0}`, `wdata={2{half}}`.
  - SW and other funct3 values: `be=4'b1111`.
- `wb_reg_write` is forced to 0 when `rd`=0.
- All outputs reset to 0. State resets to IDLE.
- Reset mid-access drops `dmem_req` immediately and abandons the access. A late response after reset is ignored.

## Timing
- Non-memory op accepted in cycle N: `wb_valid` in N+1. Back-to-back throughput is 1/cycle.
- Store accepted in cycle N: `dmem_req` from N+1 until the cycle `dmem_gnt` is high (G). `wb_valid` in G+1. Minimum latency is 2.
- Load: `dmem_req` from N+1 until G. Response accepted in cycle R > G. `wb_valid` in R+1. Minimum latency is 3.
- `dmem_rvalid` arriving in the same cycle as `dmem_gnt` is not accepted.
- `in_ready` is low from N+1 until the cycle the FSM returns to IDLE. A new instruction can be accepted in the same cycle `wb_valid` is high.
- `wb_valid` has no backpressure. It is exactly one cycle per accepted instruction.
- `dmem_*` outputs are registered and stable throughout REQ.

## Configuration
- `MISALIGN_TRAP_EN` defined:
  - Misaligned accesses are halfword with `addr[0]`=1, or word with `addr[1:0]`≠0.
  - A misaligned access never enters REQ.
  - It emits `wb_valid` in N+1 with `wb_reg_write`=0, and `misalign_err`=1 for that cycle.
- Not defined: no check is made. Low address bits beyond those listed above are ignored. `misalign_err` is constant 0.

## Structure
- Shared package `pipe_pkg`:
  - funct3 load/store encodings (LB, LH, LW, LBU, LHU, SB, SH, SW).
  - `mem_state_t` enum {IDLE, REQ, RESP}.
  - XLEN constant.
- One sub-module, `load_align`: combinational lane select and sign/zero extension from (`rdata`, `addr[1:0]`, `funct3`).

## Test plan
- ADD result 0x0000_1234, rd=5, `reg_write`=1 -> next cycle: `wb_valid`=1, `wb_data`=0x1234, `wb_rd`=5. Repeat back-to-back for 4 cycles: 4 consecutive pulses.
- SB addr 0x103, `store_data`=0xA5, `gnt` delayed 3 cycles -> `dmem_addr`=0x100, `be`=1000, `wdata`=0xA5A5A5A5 stable for all 3 cycles. `wb_valid` with `wb_reg_write`=0 one cycle after `gnt`. `in_ready`=0 throughout.
- LB addr 0x102, `rdata`=0x0080_0000 -> `wb_data`=0xFFFF_FF80. LBU same -> 0x0000_0080. LH addr 0x102, `rdata`=0x8001_0000 -> 0xFFFF_8001.
- LW with rd=0 -> `wb_valid`=1 with `wb_reg_write`=0. `rvalid` asserted in REQ or IDLE -> ignored, FSM unaffected.
- Assert `rst` while in RESP -> `dmem_req`, `wb_valid`, `in_ready` go to reset values immediately. A subsequent `rvalid` produces no `wb_valid`.
- `MISALIGN_TRAP_EN`: LW addr 0x102 -> no `dmem_req`, next cycle `wb_valid`=1, `misalign_err`=1, `wb_reg_write`=0. Without the macro -> normal access at `dmem_addr`=0x100.
